// File: rtl/fpu_issue_sched_if.sv
// Requester/FPU handshake bundle for the shared FPU issue scheduler.
// master drives requests and the branch flush; slave is the scheduler.
interface fpu_issue_sched_if #(
    parameter int UOP_W = 199,
    parameter int SQN_W = 7
);
    logic             IN_branchValid;
    logic [SQN_W-1:0] IN_branchSqN;

    logic             IN_aValid;
    logic [UOP_W-1:0] IN_aUop;
    logic [SQN_W-1:0] IN_aSqN;
    logic             IN_aMulti;
    logic             OUT_aReady;

    logic             IN_bValid;
    logic [UOP_W-1:0] IN_bUop;
    logic [SQN_W-1:0] IN_bSqN;
    logic             IN_bMulti;
    logic             OUT_bReady;

    logic             OUT_fpuValid;
    logic [UOP_W-1:0] OUT_fpuUop;
    logic             OUT_busy;

    modport master (
        output IN_branchValid, IN_branchSqN,
        output IN_aValid, IN_aUop, IN_aSqN, IN_aMulti,
        output IN_bValid, IN_bUop, IN_bSqN, IN_bMulti,
        input  OUT_aReady, OUT_bReady,
        input  OUT_fpuValid, OUT_fpuUop, OUT_busy
    );

    modport slave (
        input  IN_branchValid, IN_branchSqN,
        input  IN_aValid, IN_aUop, IN_aSqN, IN_aMulti,
        input  IN_bValid, IN_bUop, IN_bSqN, IN_bMulti,
        output OUT_aReady, OUT_bReady,
        output OUT_fpuValid, OUT_fpuUop, OUT_busy
    );
endinterface

// File: rtl/fpu_issue_sched.sv
// Round-robin scheduler sharing one FPU port between two 2-entry queues,
// with multi-cycle occupancy and sqN-based mispredict squashing.
module fpu_issue_sched #(
    parameter int UOP_W  = 199,
    parameter int SQN_W  = 7,
    parameter int MC_LAT = 8
) (
    input  logic             clk,
    input  logic             rst,
    fpu_issue_sched_if.slave io
);
    localparam int CW = $clog2(MC_LAT + 1);

    typedef struct packed {
        logic [UOP_W-1:0] uop;
        logic [SQN_W-1:0] sqN;
        logic             multi;
    } entry_t;

    typedef enum logic {IDLE, BUSY} state_t;

    // Younger than the branch: positive signed distance, wrap-safe.
    function automatic logic kill(
        input logic [SQN_W-1:0] s,
        input logic             bv,
        input logic [SQN_W-1:0] bs
    );
        logic [SQN_W-1:0] d;
        d = s - bs;
        return bv && !d[SQN_W-1] && (d != '0);
    endfunction

    state_t           state, nState;
    logic [CW-1:0]    counter, nCounter;
    logic [SQN_W-1:0] busySqN, nBusySqN;
    logic             lastB, nLastB;

    entry_t           q[2][2];
    entry_t           nQ[2][2];
    logic [1:0]       cnt[2];
    logic [1:0]       nCnt[2];
    logic [1:0]       fill[2];

    entry_t           inEntry[2];
    logic             inValid[2];
    logic             cand[2];
    logic             enq[2];
    logic             deq[2];

    logic             pick, pickB;
    entry_t           picked;
    logic             fpuValid;
    logic [UOP_W-1:0] fpuUop;

    logic             brValid;
    logic [SQN_W-1:0] brSqN;

    assign brValid = io.IN_branchValid;
    assign brSqN   = io.IN_branchSqN;

    always_comb begin
        inEntry[0] = {io.IN_aUop, io.IN_aSqN, io.IN_aMulti};
        inEntry[1] = {io.IN_bUop, io.IN_bSqN, io.IN_bMulti};
        inValid[0] = io.IN_aValid;
        inValid[1] = io.IN_bValid;
        for (int r = 0; r < 2; r++) begin
            cand[r] = (cnt[r] != 2'd0)
                && !kill(q[r][0].sqN, brValid, brSqN);
            enq[r]  = inValid[r] && (cnt[r] < 2'd2)
                && !kill(inEntry[r].sqN, brValid, brSqN);
        end

        pick     = 1'b0;
        pickB    = 1'b0;
        nLastB   = lastB;
        nState   = state;
        nCounter = counter;
        nBusySqN = busySqN;

        unique case (state)
            IDLE: begin
                pick  = cand[0] || cand[1];
                pickB = (cand[0] && cand[1]) ? !lastB : cand[1];
                if (pick) nLastB = pickB;
            end
            BUSY: begin
                if (kill(busySqN, brValid, brSqN)
                    || counter == CW'(1)) begin
                    nState   = IDLE;
                    nCounter = '0;
                end else begin
                    nCounter = counter - CW'(1);
                end
            end
            default: ;
        endcase

        picked = pickB ? q[1][0] : q[0][0];
        deq[0] = pick && !pickB;
        deq[1] = pick && pickB;

        if (pick && picked.multi) begin
            nState   = BUSY;
            nCounter = CW'(MC_LAT - 1);
            nBusySqN = picked.sqN;
        end
    end

    // Killed entries are tail-contiguous, so survivors keep their slots.
    always_comb begin
        for (int r = 0; r < 2; r++) begin
            nQ[r][0] = q[r][0];
            nQ[r][1] = q[r][1];
            if (cnt[r] == 2'd0 || kill(q[r][0].sqN, brValid, brSqN))
                fill[r] = 2'd0;
            else if (cnt[r] == 2'd2
                && !kill(q[r][1].sqN, brValid, brSqN))
                fill[r] = 2'd2;
            else
                fill[r] = 2'd1;
            if (deq[r]) begin
                nQ[r][0] = q[r][1];
                fill[r]  = fill[r] - 2'd1;
            end
            if (enq[r]) begin
                nQ[r][fill[r][0]] = inEntry[r];
                fill[r] = fill[r] + 2'd1;
            end
            nCnt[r] = fill[r];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            counter  <= '0;
            busySqN  <= '0;
            lastB    <= 1'b1;
            fpuValid <= 1'b0;
            cnt[0]   <= 2'd0;
            cnt[1]   <= 2'd0;
        end else begin
            state    <= nState;
            counter  <= nCounter;
            busySqN  <= nBusySqN;
            lastB    <= nLastB;
            fpuValid <= pick;
            cnt[0]   <= nCnt[0];
            cnt[1]   <= nCnt[1];
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < 2; r++) begin
            q[r][0] <= nQ[r][0];
            q[r][1] <= nQ[r][1];
        end
        if (pick) fpuUop <= picked.uop;
    end

    assign io.OUT_aReady   = cnt[0] < 2'd2;
    assign io.OUT_bReady   = cnt[1] < 2'd2;
    assign io.OUT_fpuValid = fpuValid;
    assign io.OUT_fpuUop   = fpuUop;
    assign io.OUT_busy     = (state == BUSY);
endmodule

// File: tb/tb_fpu_issue_sched.sv
// Bench for fpu_issue_sched: queue-level reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_fpu_issue_sched;
    localparam int UOP_W  = 199;
    localparam int SQN_W  = 7;
    localparam int MC_LAT = 8;
    localparam int SQN_M  = 1 << SQN_W;

    typedef struct {
        logic [UOP_W-1:0] uop;
        int               sqN;
        bit               multi;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int nChecks = 0;
    int nFails  = 0;

    fpu_issue_sched_if #(.UOP_W(UOP_W), .SQN_W(SQN_W)) bus ();

    fpu_issue_sched #(
        .UOP_W(UOP_W), .SQN_W(SQN_W), .MC_LAT(MC_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [UOP_W-1:0] mkUop(int k);
        logic [63:0] w;
        w = 64'hC0DE_5A00_0000_0000 | 64'(k);
        return {7'(k), w, ~w, w ^ 64'h0F0F_0F0F_0F0F_0F0F};
    endfunction

    function automatic bit mKill(bit bv, int s, int b);
        int d;
        d = (s - b) & (SQN_M - 1);
        return bv && d > 0 && d < SQN_M / 2;
    endfunction

    task automatic chk(string nm, logic [UOP_W-1:0] got,
                       logic [UOP_W-1:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s @%0t: got %0h expected %0h",
                     nm, $time, got, exp);
        end
    endtask

    // Reference model: queues per requester, countdown for occupancy.
    ent_t             mqA[$];
    ent_t             mqB[$];
    ent_t             tmp[$];
    ent_t             pe;
    bit               mStarted = 0;
    bit               mValid   = 0;
    logic [UOP_W-1:0] mUop     = '0;
    int               mBusyLeft = 0;
    int               mBusySqN  = 0;
    bit               mLastB    = 1;
    bit               bv, rdyA, rdyB, cA, cB, mPick, mPickB;
    int               bs;

    always @(posedge clk) begin
        if (rst) begin
            mqA.delete();
            mqB.delete();
            mValid    = 0;
            mBusyLeft = 0;
            mLastB    = 1;
            mStarted  = 1;
        end else begin
            bv   = bus.IN_branchValid;
            bs   = int'(bus.IN_branchSqN);
            rdyA = mqA.size() < 2;
            rdyB = mqB.size() < 2;
            mPick  = 0;
            mPickB = 0;
            if (mBusyLeft == 0) begin
                cA = 0;
                cB = 0;
                if (mqA.size() > 0) cA = !mKill(bv, mqA[0].sqN, bs);
                if (mqB.size() > 0) cB = !mKill(bv, mqB[0].sqN, bs);
                mPick  = cA || cB;
                mPickB = (cA && cB) ? !mLastB : cB;
                if (mPick) mLastB = mPickB;
            end else if (mKill(bv, mBusySqN, bs)) begin
                mBusyLeft = 0;
            end else begin
                mBusyLeft--;
            end
            tmp.delete();
            foreach (mqA[i])
                if (!mKill(bv, mqA[i].sqN, bs)) tmp.push_back(mqA[i]);
            mqA = tmp;
            tmp.delete();
            foreach (mqB[i])
                if (!mKill(bv, mqB[i].sqN, bs)) tmp.push_back(mqB[i]);
            mqB = tmp;
            mValid = mPick;
            if (mPick) begin
                pe   = mPickB ? mqB.pop_front() : mqA.pop_front();
                mUop = pe.uop;
                if (pe.multi) begin
                    mBusyLeft = MC_LAT - 1;
                    mBusySqN  = pe.sqN;
                end
            end
            if (bus.IN_aValid && rdyA
                && !mKill(bv, int'(bus.IN_aSqN), bs))
                mqA.push_back('{bus.IN_aUop, int'(bus.IN_aSqN),
                                bus.IN_aMulti});
            if (bus.IN_bValid && rdyB
                && !mKill(bv, int'(bus.IN_bSqN), bs))
                mqB.push_back('{bus.IN_bUop, int'(bus.IN_bSqN),
                                bus.IN_bMulti});
        end
    end

    always @(negedge clk) begin
        if (mStarted) begin
            chk("cmp fpuValid", UOP_W'(bus.OUT_fpuValid), UOP_W'(mValid));
            chk("cmp busy", UOP_W'(bus.OUT_busy), UOP_W'(mBusyLeft > 0));
            chk("cmp aReady", UOP_W'(bus.OUT_aReady),
                UOP_W'(mqA.size() < 2));
            chk("cmp bReady", UOP_W'(bus.OUT_bReady),
                UOP_W'(mqB.size() < 2));
            if (mValid) chk("cmp fpuUop", bus.OUT_fpuUop, mUop);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idleIn();
        bus.IN_branchValid = 1'b0;
        bus.IN_branchSqN   = '0;
        bus.IN_aValid      = 1'b0;
        bus.IN_aUop        = '0;
        bus.IN_aSqN        = '0;
        bus.IN_aMulti      = 1'b0;
        bus.IN_bValid      = 1'b0;
        bus.IN_bUop        = '0;
        bus.IN_bSqN        = '0;
        bus.IN_bMulti      = 1'b0;
    endtask

    task automatic setA(bit v, int k, int s, bit m);
        bus.IN_aValid = v;
        bus.IN_aUop   = mkUop(k);
        bus.IN_aSqN   = SQN_W'(s);
        bus.IN_aMulti = m;
    endtask

    task automatic setB(bit v, int k, int s, bit m);
        bus.IN_bValid = v;
        bus.IN_bUop   = mkUop(k);
        bus.IN_bSqN   = SQN_W'(s);
        bus.IN_bMulti = m;
    endtask

    task automatic setBr(bit v, int s);
        bus.IN_branchValid = v;
        bus.IN_branchSqN   = SQN_W'(s);
    endtask

    task automatic doReset();
        rst = 1'b1;
        idleIn();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Two A entries queued behind a multi op on B, then a flush.
    task automatic flushCase(string nm, int hold, int s0, int s1, int br);
        int               seen;
        logic [UOP_W-1:0] first;
        doReset();
        setB(1, 90, hold, 1);
        tick();
        idleIn();
        setA(1, s0, s0, 0);
        tick();
        setA(1, s1, s1, 0);
        tick();
        chk({nm, " aReady full"}, UOP_W'(bus.OUT_aReady), UOP_W'(0));
        setA(1, (s1 + 1) % SQN_M, (s1 + 1) % SQN_M, 0);
        setBr(1, br);
        tick();
        chk({nm, " aReady after flush"}, UOP_W'(bus.OUT_aReady), UOP_W'(1));
        tick();
        chk({nm, " young enq dropped"}, UOP_W'(bus.OUT_aReady), UOP_W'(1));
        idleIn();
        seen  = 0;
        first = '0;
        for (int i = 0; i < 16; i++) begin
            if (bus.OUT_fpuValid) begin
                if (seen == 0) first = bus.OUT_fpuUop;
                seen++;
            end
            tick();
        end
        chk({nm, " issue count"}, UOP_W'(seen), UOP_W'(1));
        chk({nm, " survivor uop"}, first, mkUop(s0));
    endtask

    initial begin
        int busyCnt;
        int gap;
        int seen;
        idleIn();
        doReset();
        chk("reset fpuValid", UOP_W'(bus.OUT_fpuValid), UOP_W'(0));
        chk("reset busy", UOP_W'(bus.OUT_busy), UOP_W'(0));
        chk("reset aReady", UOP_W'(bus.OUT_aReady), UOP_W'(1));
        chk("reset bReady", UOP_W'(bus.OUT_bReady), UOP_W'(1));

        // Single A op: valid on the second edge.
        setA(1, 1, 5, 0);
        tick();
        idleIn();
        chk("t1 no early valid", UOP_W'(bus.OUT_fpuValid), UOP_W'(0));
        chk("t1 aReady", UOP_W'(bus.OUT_aReady), UOP_W'(1));
        tick();
        chk("t1 valid", UOP_W'(bus.OUT_fpuValid), UOP_W'(1));
        chk("t1 uop", bus.OUT_fpuUop, mkUop(1));
        tick();
        chk("t1 pulse", UOP_W'(bus.OUT_fpuValid), UOP_W'(0));

        // Round robin A1,B3,A2,B4.
        doReset();
        setA(1, 11, 1, 0);
        setB(1, 13, 3, 0);
        tick();
        setA(1, 12, 2, 0);
        setB(1, 14, 4, 0);
        tick();
        idleIn();
        chk("t2 uop A1", bus.OUT_fpuUop, mkUop(11));
        chk("t2 bReady full", UOP_W'(bus.OUT_bReady), UOP_W'(0));
        tick();
        chk("t2 uop B3", bus.OUT_fpuUop, mkUop(13));
        chk("t2 bReady", UOP_W'(bus.OUT_bReady), UOP_W'(1));
        tick();
        chk("t2 uop A2", bus.OUT_fpuUop, mkUop(12));
        tick();
        chk("t2 uop B4", bus.OUT_fpuUop, mkUop(14));
        chk("t2 valid B4", UOP_W'(bus.OUT_fpuValid), UOP_W'(1));
        tick();
        chk("t2 drained", UOP_W'(bus.OUT_fpuValid), UOP_W'(0));

        // Multi op occupancy with B pending and A filling up.
        doReset();
        setA(1, 30, 30, 1);
        setB(1, 31, 31, 0);
        tick();
        idleIn();
        tick();
        chk("t3 multi uop", bus.OUT_fpuUop, mkUop(30));
        busyCnt = 0;
        gap     = -1;
        for (int i = 0; i < 14; i++) begin
            if (bus.OUT_busy) busyCnt++;
            if (i > 0 && gap < 0 && bus.OUT_fpuValid
                && bus.OUT_fpuUop == mkUop(31))
                gap = i;
            if (i >= 1 && i <= 3) setA(1, 31 + i, 31 + i, 0);
            else idleIn();
            tick();
        end
        chk("t3 busy cycles", UOP_W'(busyCnt), UOP_W'(7));
        chk("t3 B issue gap", UOP_W'(gap), UOP_W'(8));

        flushCase("t4", 5, 10, 12, 11);
        flushCase("t5 wrap", 125, 120, 1, 126);

        // Abort of an in-flight multi op.
        doReset();
        setA(1, 20, 20, 1);
        tick();
        idleIn();
        setB(1, 3, 3, 0);
        tick();
        idleIn();
        tick();
        tick();
        tick();
        chk("t6 busy before abort", UOP_W'(bus.OUT_busy), UOP_W'(1));
        setBr(1, 15);
        tick();
        idleIn();
        chk("t6 aborted busy", UOP_W'(bus.OUT_busy), UOP_W'(0));
        chk("t6 aborted valid", UOP_W'(bus.OUT_fpuValid), UOP_W'(0));
        tick();
        chk("t6 B valid", UOP_W'(bus.OUT_fpuValid), UOP_W'(1));
        chk("t6 B uop", bus.OUT_fpuUop, mkUop(3));

        // Reset mid-BUSY with a full B buffer.
        doReset();
        setA(1, 40, 40, 1);
        setB(1, 41, 41, 0);
        tick();
        idleIn();
        setB(1, 42, 42, 0);
        tick();
        setB(1, 43, 43, 0);
        tick();
        chk("t6r busy", UOP_W'(bus.OUT_busy), UOP_W'(1));
        chk("t6r bReady full", UOP_W'(bus.OUT_bReady), UOP_W'(0));
        rst = 1'b1;
        idleIn();
        tick();
        chk("t6r busy cleared", UOP_W'(bus.OUT_busy), UOP_W'(0));
        chk("t6r valid cleared", UOP_W'(bus.OUT_fpuValid), UOP_W'(0));
        chk("t6r aReady", UOP_W'(bus.OUT_aReady), UOP_W'(1));
        chk("t6r bReady", UOP_W'(bus.OUT_bReady), UOP_W'(1));
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.OUT_fpuValid) seen++;
            tick();
        end
        chk("t6r dropped", UOP_W'(seen), UOP_W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFails);
        $finish;
    end
endmodule
